// File: rtl/mem_port_arbiter.sv
// Single-port SRAM arbiter: round-robin grant with burst locking, lock idle
// timeout, and a one-cycle read-return tag that steers rvalid to the issuer.
module mem_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ-1:0]          we_i,
  input  logic [NUM_REQ-1:0]          lock_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   wdata_i,
  input  logic [NUM_REQ*DATA_W/8-1:0] be_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic [NUM_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]           rdata_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W/8-1:0]         mem_be_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int          IDX_W  = $clog2(NUM_REQ);
  localparam int          CNT_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam int          BE_W   = DATA_W / 8;
  localparam int unsigned NREQ_U = NUM_REQ;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_e;

  state_e             state_q, state_n;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_n;
  logic [IDX_W-1:0]   owner_q, owner_n;
  logic [CNT_W-1:0]   idle_cnt_q, idle_cnt_n;
  logic [NUM_REQ-1:0] rtag_q;
  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic [IDX_W-1:0]   cand;
  logic               gnt_any;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Grant is gated by rst_ni so nothing reaches the SRAM while in reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (rst_ni) begin
      if (state_q == ST_LOCKED) begin
        if (req_i[owner_q]) begin
          gnt[owner_q] = 1'b1;
          gnt_idx      = owner_q;
          gnt_any      = 1'b1;
        end
      end else begin
        for (int unsigned i = 0; i < NREQ_U; i++) begin
          cand = IDX_W'((32'(rr_ptr_q) + i) % NREQ_U);
          if (!gnt_any && req_i[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            gnt_any   = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_n    = state_q;
    rr_ptr_n   = rr_ptr_q;
    owner_n    = owner_q;
    idle_cnt_n = '0;
    case (state_q)
      ST_OPEN: begin
        if (gnt_any) begin
          rr_ptr_n = wrap_inc(gnt_idx);
          if (lock_i[gnt_idx]) begin
            state_n = ST_LOCKED;
            owner_n = gnt_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (gnt_any) begin
          if (!lock_i[gnt_idx]) state_n = ST_OPEN;
        end else if (idle_cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          // Forced release: fairness resumes just past the stale owner.
          state_n  = ST_OPEN;
          rr_ptr_n = wrap_inc(owner_q);
        end else begin
          idle_cnt_n = idle_cnt_q + CNT_W'(1);
        end
      end
      default: state_n = ST_OPEN;
    endcase
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int unsigned i = 0; i < NREQ_U; i++) begin
      if (gnt[i]) begin
        mem_we_o    |= we_i[i];
        mem_addr_o  |= addr_i[i*ADDR_W +: ADDR_W];
        mem_be_o    |= be_i[i*BE_W +: BE_W];
        mem_wdata_o |= wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_OPEN;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      idle_cnt_q <= '0;
      rtag_q     <= '0;
    end else begin
      state_q    <= state_n;
      rr_ptr_q   <= rr_ptr_n;
      owner_q    <= owner_n;
      idle_cnt_q <= idle_cnt_n;
      rtag_q     <= gnt & ~we_i;
    end
  end

  assign gnt_o     = gnt;
  assign mem_req_o = gnt_any;
  assign rvalid_o  = rtag_q;
  assign rdata_o   = mem_rdata_i;

endmodule
